// File: rtl/cpu_run_pkg.sv
// Shared types and constants for the CPU run controller.
package cpu_run_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_HOLD    = 2'd0,
    ST_RUN     = 2'd1,
    ST_DONE    = 2'd2,
    ST_TIMEOUT = 2'd3
  } run_state_e;

endpackage

// File: rtl/core_halt_det.sv
// Per-core halt detector: sticky halt flag set by an explicit halt strobe
// or by the PC staying unchanged for STALL_LIMIT consecutive enabled cycles.
module core_halt_det #(
  parameter int PC_W        = 32,
  parameter int STALL_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            en,
  input  logic [PC_W-1:0] pc,
  input  logic            halt,
  output logic            halted
);

  localparam int                 STALL_W   = $clog2(STALL_LIMIT + 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_LIMIT);
  localparam logic [STALL_W-1:0] STALL_ONE = STALL_W'(1);

  logic [PC_W-1:0]    last_pc_q,   last_pc_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic               pc_valid_q,  pc_valid_d;
  logic               halted_q,    halted_d;

  // Next-state: clear on restart, otherwise track the PC while enabled.
  always_comb begin
    last_pc_d   = last_pc_q;
    stall_cnt_d = stall_cnt_q;
    pc_valid_d  = pc_valid_q;
    halted_d    = halted_q;
    if (clr) begin
      last_pc_d   = '0;
      stall_cnt_d = '0;
      pc_valid_d  = 1'b0;
      halted_d    = 1'b0;
    end else if (en) begin
      last_pc_d  = pc;
      pc_valid_d = 1'b1;
      if (halt) begin
        halted_d = 1'b1;
      end else if (pc_valid_q && (pc == last_pc_q)) begin
        // Saturating stall count; the flag sets on reaching the limit.
        if (stall_cnt_q != STALL_MAX) begin
          stall_cnt_d = stall_cnt_q + STALL_ONE;
        end else begin
          stall_cnt_d = stall_cnt_q;
        end
        if (stall_cnt_d == STALL_MAX) begin
          halted_d = 1'b1;
        end else begin
          halted_d = halted_q;
        end
      end else begin
        stall_cnt_d = '0;
      end
    end else begin
      // Outside RUN the detector is frozen.
      halted_d = halted_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_pc_q   <= '0;
      stall_cnt_q <= '0;
      pc_valid_q  <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      last_pc_q   <= last_pc_d;
      stall_cnt_q <= stall_cnt_d;
      pc_valid_q  <= pc_valid_d;
      halted_q    <= halted_d;
    end
  end

  assign halted = halted_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller: holds the cores in reset for RST_CYCLES edges, counts run
// cycles, and ends the run with DONE (all cores halted) or TIMEOUT (budget).
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter  int NUM_CORES   = 1,
  parameter  int PC_W        = 32,
  parameter  int RST_CYCLES  = 2,
  parameter  int MAX_CYCLES  = 1000,
  parameter  int STALL_LIMIT = 4,
  localparam int CNT_W       = $clog2(MAX_CYCLES + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CORES*PC_W-1:0] pc_i,
  input  logic [NUM_CORES-1:0]      halt_i,
  input  logic                      restart_i,
  output logic                      core_rst_o,
  output logic [CNT_W-1:0]          cycle_cnt_o,
  output logic [NUM_CORES-1:0]      halted_o,
  output logic                      done_o,
  output logic                      timeout_o,
  output logic [STATE_W-1:0]        state_o
);

  localparam int                HOLD_W    = $clog2(RST_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MAX_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  run_state_e           state_q,     state_d;
  logic [HOLD_W-1:0]    hold_cnt_q,  hold_cnt_d;
  logic                 core_rst_q,  core_rst_d;
  logic [CNT_W-1:0]     cycle_cnt_q, cycle_cnt_d;
  logic                 done_q,      done_d;
  logic                 timeout_q,   timeout_d;

  logic [NUM_CORES-1:0] halted_s;
  logic                 all_halted_s;
  logic                 det_en_s;
  logic                 det_clr_s;
  logic                 finished_s;

  assign finished_s   = (state_q == ST_DONE) || (state_q == ST_TIMEOUT);
  assign det_en_s     = (state_q == ST_RUN);
  assign det_clr_s    = finished_s && restart_i;
  assign all_halted_s = &halted_s;

  for (genvar k = 0; k < NUM_CORES; k++) begin : g_det
    core_halt_det #(
      .PC_W        (PC_W),
      .STALL_LIMIT (STALL_LIMIT)
    ) u_det (
      .clk    (clk),
      .rst    (rst),
      .clr    (det_clr_s),
      .en     (det_en_s),
      .pc     (pc_i[k*PC_W +: PC_W]),
      .halt   (halt_i[k]),
      .halted (halted_s[k])
    );
  end

  // FSM next-state: reset hold, run counting, and terminal observation.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    core_rst_d  = core_rst_q;
    cycle_cnt_d = cycle_cnt_q;
    done_d      = done_q;
    timeout_d   = timeout_q;
    case (state_q)
      ST_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d    = ST_RUN;
          core_rst_d = 1'b0;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_ONE;
        end
      end
      ST_RUN: begin
        // All-halted is checked first so it wins a tie with the budget.
        if (all_halted_s) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (cycle_cnt_q == CNT_LAST) begin
          state_d     = ST_TIMEOUT;
          timeout_d   = 1'b1;
          cycle_cnt_d = CNT_MAX;
        end else begin
          cycle_cnt_d = cycle_cnt_q + CNT_ONE;
        end
      end
      ST_DONE, ST_TIMEOUT: begin
        if (restart_i) begin
          state_d     = ST_HOLD;
          core_rst_d  = 1'b1;
          hold_cnt_d  = '0;
          cycle_cnt_d = '0;
          done_d      = 1'b0;
          timeout_d   = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d    = ST_HOLD;
        core_rst_d = 1'b1;
        hold_cnt_d = '0;
      end
    endcase
  end

  // FSM and counter registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_HOLD;
      hold_cnt_q  <= '0;
      core_rst_q  <= 1'b1;
      cycle_cnt_q <= '0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      core_rst_q  <= core_rst_d;
      cycle_cnt_q <= cycle_cnt_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
    end
  end

  assign core_rst_o  = core_rst_q;
  assign cycle_cnt_o = cycle_cnt_q;
  assign halted_o    = halted_s;
  assign done_o      = done_q;
  assign timeout_o   = timeout_q;
  assign state_o     = state_q;

endmodule
